// File: rtl/cajero_transaccion.sv
// ATM transaction stage: after an accepted PIN, captures one deposit or withdrawal,
// updates the held balance and reports the outcome with registered one-cycle pulses.
module cajero_transaccion #(
  parameter int unsigned BALANCE_W   = 64,
  parameter int unsigned MONTO_W     = 32,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pin_ok,
  input  logic                 balance_load,
  input  logic [BALANCE_W-1:0] balance_in,
  input  logic                 tipo_trans,
  input  logic                 monto_stb,
  input  logic [MONTO_W-1:0]   monto,
  output logic [BALANCE_W-1:0] balance_out,
  output logic                 balance_actualizado,
  output logic                 entregar_dinero,
  output logic                 fondos_insuficientes,
  output logic                 timeout,
  output logic                 ocupado
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [4:0] {
    StIdle     = 5'b00001,
    StEspera   = 5'b00010,
    StDeposito = 5'b00100,
    StRetiro   = 5'b01000,
    StFin      = 5'b10000
  } state_e;

  state_e               state_q;
  logic [BALANCE_W-1:0] balance_q;
  logic [CntW-1:0]      cnt_q;
  logic [MONTO_W-1:0]   monto_q;
  logic                 actualizado_q;
  logic                 entregar_q;
  logic                 insuficientes_q;
  logic                 timeout_q;

  logic [BALANCE_W-1:0] monto_ext;
  logic [BALANCE_W:0]   suma;

  always_comb begin
    monto_ext = BALANCE_W'(monto_q);
    suma      = {1'b0, balance_q} + {1'b0, monto_ext};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      balance_q       <= '0;
      cnt_q           <= '0;
      monto_q         <= '0;
      actualizado_q   <= 1'b0;
      entregar_q      <= 1'b0;
      insuficientes_q <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      // Pulses default low; each is set for exactly the one cycle following its cause.
      actualizado_q   <= 1'b0;
      entregar_q      <= 1'b0;
      insuficientes_q <= 1'b0;
      timeout_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (balance_load) balance_q <= balance_in;
          if (pin_ok) begin
            cnt_q   <= '0;
            state_q <= StEspera;
          end
        end
        StEspera: begin
          if (monto_stb) begin
            monto_q <= monto;
            cnt_q   <= '0;
            state_q <= tipo_trans ? StRetiro : StDeposito;
          end else if (cnt_q == CntLimit) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDeposito: begin
          balance_q     <= suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
          actualizado_q <= 1'b1;
          state_q       <= StFin;
        end
        StRetiro: begin
          if (monto_ext > balance_q) begin
            insuficientes_q <= 1'b1;
          end else begin
            balance_q  <= balance_q - monto_ext;
            entregar_q <= (monto_q != '0);
          end
          actualizado_q <= 1'b1;
          state_q       <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign balance_out          = balance_q;
  assign balance_actualizado  = actualizado_q;
  assign entregar_dinero      = entregar_q;
  assign fondos_insuficientes = insuficientes_q;
  assign timeout              = timeout_q;
  assign ocupado              = (state_q != StIdle);

endmodule
